shot_clock_controller: RTL and testbench

// - Upstream control stage of the scoreboard shot clock.
// - Synchronises the three front-panel push-buttons and generates its own 1 Hz tick from the 50 MHz board clock.
// - Runs the 24/14-second countdown state machine and drives the buzzer.
// - count feeds the binary-to-BCD converter directly, which feeds the display mux/decoder chain.

---
 rtl/shot_clock_controller.sv | 158 +++++++++++++++
 tb/tb_shot_clock_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shot_clock_controller.sv
// Shot clock control stage: button synchronise/debounce, 1 Hz prescaler, 24/14 countdown FSM, buzzer timer.
// Define SHOT_CLOCK_DEBOUNCE_EN to insert a per-button debounce counter after the synchronisers.
module shot_clock_controller #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int FULL_COUNT      = 24,
    parameter int SHORT_COUNT     = 14,
    parameter int BUZZ_TICKS      = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_start_n,
    input  logic       btn_reset24_n,
    input  logic       btn_reset14_n,
    output logic [4:0] count,
    output logic       running,
    output logic       expired,
    output logic       buzzer
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam int         PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int         BW    = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS) : 1;
    localparam logic [4:0] FULL  = 5'(FULL_COUNT);
    localparam logic [4:0] SHORT = 5'(SHORT_COUNT);

    // Button vectors are active-high "pressed": bit 0 start, bit 1 reset24, bit 2 reset14.
    logic [2:0] raw_pressed;
    logic [2:0] sync1, sync2;
    logic [2:0] db, db_prev, evt;

    assign raw_pressed = ~{btn_reset14_n, btn_reset24_n, btn_start_n};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_pressed;
            sync2 <= sync1;
        end
    end

`ifdef SHOT_CLOCK_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [DW-1:0] db_cnt [3];

    // NOTE: these counters are a tiny register array, not a RAM, so they are reset like any other flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign db = sync2;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) db_prev <= '0;
        else          db_prev <= db;
    end

    assign evt = db & ~db_prev;

    logic reload24, reload14, start_evt;
    assign reload24  = evt[1];
    assign reload14  = evt[2] & ~evt[1];
    assign start_evt = evt[0] & ~evt[1] & ~evt[2];

    state_t        state, state_nx;
    logic [4:0]    count_nx;
    logic [PW-1:0] prescale, prescale_nx;
    logic [BW-1:0] btimer, btimer_nx;
    logic          buzzer_nx;
    logic          counting, tick;

    assign counting = (state == RUN) || (state == EXPIRED);
    assign tick     = counting && (prescale == PW'(TICK_DIV - 1));

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        prescale_nx = prescale;
        btimer_nx   = btimer;
        buzzer_nx   = buzzer;

        if (counting) prescale_nx = tick ? '0 : prescale + 1'b1;

        if (reload24 || reload14) begin
            // A reload always wins over a same-cycle tick; the second restarts from zero.
            count_nx    = reload24 ? FULL : ((count < SHORT) ? SHORT : count);
            prescale_nx = '0;
            btimer_nx   = '0;
            buzzer_nx   = 1'b0;
            state_nx    = (state == RUN) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: if (start_evt) state_nx = RUN;
                RUN: begin
                    if (tick) begin
                        if (count > 5'd1) begin
                            count_nx = count - 5'd1;
                        end else begin
                            count_nx  = '0;
                            state_nx  = EXPIRED;
                            buzzer_nx = 1'b1;
                            btimer_nx = '0;
                        end
                    end
                    if (start_evt && state_nx == RUN) state_nx = PAUSE;
                end
                PAUSE: if (start_evt) state_nx = RUN;
                EXPIRED: begin
                    if (tick && buzzer) begin
                        if (btimer == BW'(BUZZ_TICKS - 1)) buzzer_nx = 1'b0;
                        else                               btimer_nx = btimer + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= FULL;
            prescale <= '0;
            btimer   <= '0;
            buzzer   <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            prescale <= prescale_nx;
            btimer   <= btimer_nx;
            buzzer   <= buzzer_nx;
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_shot_clock_controller.sv
// Directed bench for shot_clock_controller with TICK_DIV=4, DEBOUNCE_CYCLES=3, BUZZ_TICKS=2.
// Press timing adapts to whether SHOT_CLOCK_DEBOUNCE_EN is defined for the build.
module tb_shot_clock_controller;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int BUZZ     = 2;

`ifdef SHOT_CLOCK_DEBOUNCE_EN
    // 2 synchroniser edges + 3 stable samples, action one cycle after the debounced edge.
    localparam int LAT  = 5;
    localparam int HOLD = 3;
`else
    localparam int LAT  = 2;
    localparam int HOLD = 1;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_start_n, btn_reset24_n, btn_reset14_n;
    logic [4:0] count;
    logic       running, expired, buzzer;

    shot_clock_controller #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .FULL_COUNT     (24),
        .SHORT_COUNT    (14),
        .BUZZ_TICKS     (BUZZ)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_start_n  (btn_start_n),
        .btn_reset24_n(btn_reset24_n),
        .btn_reset14_n(btn_reset14_n),
        .count        (count),
        .running      (running),
        .expired      (expired),
        .buzzer       (buzzer)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // press bits: [0] start, [1] reset24, [2] reset14
    typedef struct {
        logic [2:0] press;
        int         gap;
        int         settle;
        logic [4:0] exp_count;
        logic       exp_running;
        logic       exp_expired;
        logic       exp_buzzer;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_out(input string name, input logic [4:0] c, input logic r,
                             input logic e, input logic b);
        check({name, " {count,running,expired,buzzer}"},
              {24'd0, count, running, expired, buzzer}, {24'd0, c, r, e, b});
    endtask

    task automatic drive(input logic [2:0] m);
        btn_start_n   = ~m[0];
        btn_reset24_n = ~m[1];
        btn_reset14_n = ~m[2];
    endtask

    task automatic wait_cyc(input int t);
        if (cyc > t) begin
            n_vec++;
            n_bad++;
            $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, t);
        end
        while (cyc < t) @(negedge clock);
    endtask

    // Presses so the FSM acts on posedge number t.
    task automatic press_at(input logic [2:0] m, input int t);
        wait_cyc(t - LAT - 1);
        drive(m);
        wait_cyc(t - LAT - 1 + HOLD);
        drive(3'b000);
    endtask

    task automatic wait_count(input logic [4:0] v, output int t);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clock);
            if (count == v) found = 1'b1;
        end
        t = cyc;
        check($sformatf("wait_count_%0d", v), {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t, a, x, y, high;

        vecs[0] = '{3'b100,  8, 2, 5'd24, 1'b0, 1'b0, 1'b0};  // reset14 at 24: no change
        vecs[1] = '{3'b001,  8, 6, 5'd23, 1'b1, 1'b0, 1'b0};  // start, one tick
        vecs[2] = '{3'b001, 14, 4, 5'd21, 1'b0, 1'b0, 1'b0};  // pause, prescaler at 2
        vecs[3] = '{3'b001, 12, 3, 5'd20, 1'b1, 1'b0, 1'b0};  // resume: tick 2 cycles later
        vecs[4] = '{3'b010,  9, 3, 5'd24, 1'b1, 1'b0, 1'b0};  // reset24 while running stays RUN
        vecs[5] = '{3'b001, 13, 4, 5'd21, 1'b0, 1'b0, 1'b0};  // pause
        vecs[6] = '{3'b100, 10, 3, 5'd21, 1'b0, 1'b0, 1'b0};  // reset14 at 21 -> IDLE, no change
        vecs[7] = '{3'b001,  9, 3, 5'd21, 1'b1, 1'b0, 1'b0};  // start: prescaler was cleared
        vecs[8] = '{3'b001,  9, 3, 5'd19, 1'b0, 1'b0, 1'b0};  // pause

        drive(3'b000);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_out("in_reset", 5'd24, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        check_out("after_reset", 5'd24, 1'b0, 1'b0, 1'b0);

        base = cyc;
        for (int i = 0; i < 9; i++) begin
            base += vecs[i].gap;
            press_at(vecs[i].press, base);
            wait_cyc(base + vecs[i].settle);
            check_out($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_running,
                      vecs[i].exp_expired, vecs[i].exp_buzzer);
        end

        // Resume, pause at 9, then reset14 lifts it to 14 and goes IDLE.
        press_at(3'b001, cyc + 8);
        wait_count(5'd10, t);
        press_at(3'b001, t + 6);
        wait_cyc(t + 10);
        check_out("pause_at_9", 5'd9, 1'b0, 1'b0, 1'b0);
`ifdef SHOT_CLOCK_DEBOUNCE_EN
        wait_cyc(t + 12);
        drive(3'b001);
        @(negedge clock);
        drive(3'b000);
        wait_cyc(t + 22);
        check_out("glitch_ignored", 5'd9, 1'b0, 1'b0, 1'b0);
`endif
        press_at(3'b100, t + 30);
        wait_cyc(t + 33);
        check_out("reset14_raises", 5'd14, 1'b0, 1'b0, 1'b0);

        // Run 14 -> 0, buzzer for exactly two ticks, start ignored in EXPIRED.
        a = t + 40;
        press_at(3'b001, a);
        wait_cyc(a + 55);
        check_out("count_1", 5'd1, 1'b1, 1'b0, 1'b0);
        high = 0;
        repeat (12) begin
            @(negedge clock);
            if (buzzer && expired && count == 5'd0) high++;
        end
        check("buzzer_cycles", 32'(high), 32'd8);
        check_out("expired_quiet", 5'd0, 1'b0, 1'b1, 1'b0);
        press_at(3'b001, a + 76);
        wait_cyc(a + 80);
        check_out("start_in_expired", 5'd0, 1'b0, 1'b1, 1'b0);
        press_at(3'b010, a + 90);
        wait_cyc(a + 93);
        check_out("reset24_from_expired", 5'd24, 1'b0, 1'b0, 1'b0);

        // reset24 and start together in PAUSE: reload wins, ends in IDLE.
        x = a + 100;
        press_at(3'b001, x);
        press_at(3'b001, x + 10);
        wait_cyc(x + 14);
        check_out("paused_22", 5'd22, 1'b0, 1'b0, 1'b0);
        press_at(3'b011, x + 22);
        wait_cyc(x + 25);
        check_out("r24_beats_start", 5'd24, 1'b0, 1'b0, 1'b0);
        wait_cyc(x + 35);
        check_out("still_idle", 5'd24, 1'b0, 1'b0, 1'b0);

        // Reload on the tick edge at count 5: no decrement, prescaler restarts.
        y = x + 45;
        press_at(3'b001, y);
        press_at(3'b010, y + 80);
        wait_cyc(y + 79);
        check_out("count_5", 5'd5, 1'b1, 1'b0, 1'b0);
        wait_cyc(y + 80);
        check_out("reload_on_tick", 5'd24, 1'b1, 1'b0, 1'b0);
        wait_cyc(y + 83);
        check_out("no_early_tick", 5'd24, 1'b1, 1'b0, 1'b0);
        wait_cyc(y + 84);
        check_out("tick_after_reload", 5'd23, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-run, checked before any clock edge.
        wait_cyc(y + 90);
        #1 reset_n = 1'b0;
        #1 check_out("async_reset", 5'd24, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
